br_redirect_ctrl: RTL and testbench
===================================

Name: br_redirect_ctrl

Overview:
Sequences the branch-resolution path out of EX. Takes the branch unit's taken/target result together with the prediction carried down the pipe, and detects mispredictions. On a mispredict it issues a held redirect to fetch over a valid/ready handshake, flushes wrong-path instructions, and stalls further EX resolutions until fetch accepts. It also drives the predictor update and keeps branch/mispredict statistics.

Parameters:
CNT_W, 32, width of the saturating statistics counters
XLEN, 32, address/data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ex_valid  in  1  EX stage holds a valid instruction
ex_is_branch  in  1  any branch-unit op active (jal/jalr/beq/bne/blt/bge/bltu/bgeu)
ex_pc  in  XLEN  PC of the EX instruction
ex_br_e  in  1  branch unit: taken
ex_br_addr  in  XLEN  branch unit: target
ex_pred_taken  in  1  fetch-time prediction: taken
ex_pred_target  in  XLEN  fetch-time predicted target
redir_valid  out  1  redirect request to fetch
redir_ready  in  1  fetch accepts redirect
redir_pc  out  XLEN  corrected fetch PC
flush_fe  out  1  kill IF/ID and ID/EX contents
ex_stall  out  1  hold EX, no new resolution
upd_valid  out  1  predictor update pulse
upd_pc  out  XLEN  branch PC for update
upd_taken  out  1  actual direction
upd_target  out  XLEN  actual target
clr_cnt  in  1  synchronous clear of statistics
cnt_branch  out  CNT_W  resolved branches
cnt_mispred  out  CNT_W  mispredictions

Behaviour:
- Reset (async, rst=1): state=IDLE; redir_valid=0, redir_pc=0, flush_fe=0, ex_stall=0, upd_valid=0, upd_pc=0, upd_taken=0, upd_target=0, cnt_*=0. Reset mid-redirect drops the request immediately.
- resolve = ex_valid & ex_is_branch & state==IDLE.
- mispredict = resolve & ((ex_br_e != ex_pred_taken) | (ex_br_e & ex_pred_taken & ex_br_addr != ex_pred_target)).
- correct_pc = ex_br_e ? ex_br_addr : ex_pc + 4; the add is XLEN-bit and wraps modulo 2^XLEN (0xFFFFFFFC+4 = 0).
- States:
  - IDLE: on mispredict, register redir_pc=correct_pc and go to REDIR.
  - REDIR: redir_valid=1, flush_fe=1, ex_stall=1. All are registered or decoded from state, so the first assertion occurs the cycle after resolve (latency 1).
  - REDIR -> IDLE on redir_valid & redir_ready; redirect handshake completes that cycle. flush_fe and ex_stall remain high during that cycle and drop the next.
- redir_pc is stable while redir_valid=1 and not ready. Backpressure is unbounded.
- In REDIR, ex_valid/ex_is_branch are ignored (wrong path): no update, no count.
- upd_*: registered 1-cycle pulse the cycle after every resolve (correct or mispredicted). upd_target = ex_br_addr, upd_taken = ex_br_e.
- Counters: cnt_branch += resolve; cnt_mispred += mispredict; both saturate at all-ones.
- clr_cnt has priority over a same-cycle increment; the result is 0.
- A correctly predicted branch causes no stall and no flush. Back-to-back correct branches resolve every cycle.

Decomposition:
- Shared package: state encoding (IDLE, REDIR) and the XLEN default. It also holds the bru_op bit positions {jal,jalr,beq,bne,blt,bge,bltu,bgeu}, so decode derives ex_is_branch consistently.
- One sub-module: sat_cnt (width param, inc, clr, value), instantiated twice.

Test Plan:
- Correct predict: beq at pc 0x100, ex_br_e=1, br_addr=0x140, pred_taken=1, target=0x140 -> no redir/flush/stall; upd_valid pulse next cycle; cnt_branch=1, cnt_mispred=0.
- Direction mispredict: bne at 0x200, br_e=0, pred_taken=1, redir_ready=1 -> next cycle redir_valid=1, redir_pc=0x204, flush_fe=1 for exactly 1 cycle; cnt_mispred=1.
- Target mispredict with backpressure: jalr br_addr=0x3000, pred_target=0x2000, redir_ready low 3 cycles -> redir_valid/redir_pc=0x3000 stable 4 cycles. A branch on ex_valid during the wait is not counted. IDLE follows the handshake.
- Wrap: pc=0xFFFFFFFC, br_e=0, pred_taken=1 -> redir_pc=0x00000000.
- Counters: CNT_W=4, 17 resolves -> cnt_branch=15 (saturated). clr_cnt coincident with a resolve -> 0.
- Async reset asserted in REDIR between clock edges -> redir_valid, flush_fe, ex_stall fall without a clock edge; state IDLE after release.

Source files
------------

// File: rtl/br_redirect_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | br_redirect_ctrl_pkg : shared FSM encoding and branch-unit op positions   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package br_redirect_ctrl_pkg;

  localparam int XLEN_DEF = 32;

  localparam int              ST_W     = 1;
  localparam logic [ST_W-1:0] ST_IDLE  = 1'b0;
  localparam logic [ST_W-1:0] ST_REDIR = 1'b1;

  // One-hot branch-unit op vector {jal,jalr,beq,bne,blt,bge,bltu,bgeu}
  localparam int BRU_OP_W = 8;
  localparam int BRU_JAL  = 7;
  localparam int BRU_JALR = 6;
  localparam int BRU_BEQ  = 5;
  localparam int BRU_BNE  = 4;
  localparam int BRU_BLT  = 3;
  localparam int BRU_BGE  = 2;
  localparam int BRU_BLTU = 1;
  localparam int BRU_BGEU = 0;

  function automatic logic bru_is_branch(input logic [BRU_OP_W-1:0] op);
    return |op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/br_redirect_ctrl_sat_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | br_redirect_ctrl_sat_cnt : saturating up-counter with priority clear      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module br_redirect_ctrl_sat_cnt
  import br_redirect_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/br_redirect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | br_redirect_ctrl : EX branch resolution, mispredict redirect and stats   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module br_redirect_ctrl
  import br_redirect_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_br_e,
  input  logic [XLEN-1:0]  ex_br_addr,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_pc,
  output logic             flush_fe,
  output logic             ex_stall,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic             upd_taken,
  output logic [XLEN-1:0]  upd_target,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispred
);

  logic [ST_W-1:0] state_q, state_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            upd_valid_q;
  logic [XLEN-1:0] upd_pc_q, upd_pc_d;
  logic            upd_taken_q, upd_taken_d;
  logic [XLEN-1:0] upd_target_q, upd_target_d;

  logic            resolve;
  logic            mispredict;
  logic [XLEN-1:0] correct_pc;

  // Wrong-path instructions arriving while a redirect is pending never resolve.
  assign resolve    = ex_valid & ex_is_branch & (state_q == ST_IDLE);
  assign mispredict = resolve &
                      ((ex_br_e != ex_pred_taken) |
                       (ex_br_e & ex_pred_taken & (ex_br_addr != ex_pred_target)));
  assign correct_pc = ex_br_e ? ex_br_addr : (ex_pc + XLEN'(4));

  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          state_d    = ST_REDIR;
          redir_pc_d = correct_pc;
        end
      end
      ST_REDIR: begin
        if (redir_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    upd_pc_d     = upd_pc_q;
    upd_taken_d  = upd_taken_q;
    upd_target_d = upd_target_q;
    if (resolve) begin
      upd_pc_d     = ex_pc;
      upd_taken_d  = ex_br_e;
      upd_target_d = ex_br_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      redir_pc_q   <= '0;
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      upd_target_q <= '0;
    end else begin
      state_q      <= state_d;
      redir_pc_q   <= redir_pc_d;
      upd_valid_q  <= resolve;
      upd_pc_q     <= upd_pc_d;
      upd_taken_q  <= upd_taken_d;
      upd_target_q <= upd_target_d;
    end
  end

  // Decoded straight from state so an async reset drops them without a clock.
  assign redir_valid = (state_q == ST_REDIR);
  assign flush_fe    = (state_q == ST_REDIR);
  assign ex_stall    = (state_q == ST_REDIR);
  assign redir_pc    = redir_pc_q;

  assign upd_valid   = upd_valid_q;
  assign upd_pc      = upd_pc_q;
  assign upd_taken   = upd_taken_q;
  assign upd_target  = upd_target_q;

  br_redirect_ctrl_sat_cnt #(.WIDTH(CNT_W)) u_cnt_branch (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (resolve),
    .clr_i   (clr_cnt),
    .value_o (cnt_branch)
  );

  br_redirect_ctrl_sat_cnt #(.WIDTH(CNT_W)) u_cnt_mispred (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (mispredict),
    .clr_i   (clr_cnt),
    .value_o (cnt_mispred)
  );

endmodule
`default_nettype wire

// File: tb/tb_br_redirect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_br_redirect_ctrl : scoreboard bench with behavioural reference model  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_br_redirect_ctrl;

  localparam int CNT_W   = 4;
  localparam int XLEN    = 32;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid, ex_is_branch, ex_br_e, ex_pred_taken;
  logic [XLEN-1:0]  ex_pc, ex_br_addr, ex_pred_target;
  logic             redir_valid, redir_ready, flush_fe, ex_stall;
  logic [XLEN-1:0]  redir_pc, upd_pc, upd_target;
  logic             upd_valid, upd_taken, clr_cnt;
  logic [CNT_W-1:0] cnt_branch, cnt_mispred;

  br_redirect_ctrl #(.CNT_W(CNT_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_br_e(ex_br_e), .ex_br_addr(ex_br_addr),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .flush_fe(flush_fe), .ex_stall(ex_stall),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .clr_cnt(clr_cnt), .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } upd_t;

  upd_t            upd_q[$];
  logic [XLEN-1:0] redir_q[$];
  bit              m_busy;
  int              m_cnt_b, m_cnt_m;
  bit              mon_en;
  int              n_checks, n_errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a redirect is outstanding until fetch takes it; while
  // outstanding nothing resolves. Next-PC comparison defines a mispredict.
  logic [XLEN-1:0] pred_next, act_next;
  bit              m_res, m_mis;
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_cnt_b = 0; m_cnt_m = 0;
      upd_q.delete(); redir_q.delete();
    end else begin
      m_res     = !m_busy && ex_valid && ex_is_branch;
      pred_next = ex_pred_taken ? ex_pred_target : ex_pc + 32'd4;
      act_next  = ex_br_e ? ex_br_addr : ex_pc + 32'd4;
      m_mis     = m_res && ((ex_pred_taken != ex_br_e) || (pred_next != act_next));
      if (m_busy && redir_ready) m_busy = 0;
      if (m_res) upd_q.push_back('{pc: ex_pc, taken: ex_br_e, target: ex_br_addr});
      if (m_mis) begin
        redir_q.push_back(act_next);
        m_busy = 1;
      end
      if (clr_cnt) begin
        m_cnt_b = 0; m_cnt_m = 0;
      end else begin
        if (m_res && m_cnt_b < CNT_MAX) m_cnt_b++;
        if (m_mis && m_cnt_m < CNT_MAX) m_cnt_m++;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("redir_valid", redir_valid, m_busy);
      chk("flush_fe", flush_fe, m_busy);
      chk("ex_stall", ex_stall, m_busy);
      if (redir_valid) begin
        if (redir_q.size() == 0) begin
          chk("redir_unexpected", 1, 0);
        end else begin
          chk("redir_pc", redir_pc, redir_q[0]);
          if (redir_ready) void'(redir_q.pop_front());
        end
      end
      if (upd_q.size() > 0) begin
        upd_t e;
        e = upd_q.pop_front();
        chk("upd_valid", upd_valid, 1);
        if (upd_valid) begin
          chk("upd_pc", upd_pc, e.pc);
          chk("upd_taken", upd_taken, e.taken);
          chk("upd_target", upd_target, e.target);
        end
      end else begin
        chk("upd_valid_idle", upd_valid, 0);
      end
      chk("cnt_branch", cnt_branch, m_cnt_b);
      chk("cnt_mispred", cnt_mispred, m_cnt_m);
    end
  end

  task automatic step(input logic v, input logic br, input logic [XLEN-1:0] pc,
                      input logic e, input logic [XLEN-1:0] addr, input logic pt,
                      input logic [XLEN-1:0] ptgt, input logic rdy, input logic clr);
    ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_br_e = e; ex_br_addr = addr;
    ex_pred_taken = pt; ex_pred_target = ptgt; redir_ready = rdy; clr_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, '0, 0, '0, 0, '0, rdy, 0);
  endtask

  initial begin
    logic [XLEN-1:0] pc, addr, ptgt;
    logic            e, pt;
    n_checks = 0; n_errors = 0; mon_en = 0;
    rst = 1;
    ex_valid = 0; ex_is_branch = 0; ex_pc = '0; ex_br_e = 0; ex_br_addr = '0;
    ex_pred_taken = 0; ex_pred_target = '0; redir_ready = 0; clr_cnt = 0;
    #2;
    chk("rst_redir_valid", redir_valid, 0);
    chk("rst_redir_pc", redir_pc, 0);
    chk("rst_flush", flush_fe, 0);
    chk("rst_stall", ex_stall, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_upd_target", {upd_taken, upd_target}, 0);
    chk("rst_cnt", {cnt_branch, cnt_mispred}, 0);
    idle(0); idle(0);
    rst = 0; mon_en = 1;
    idle(0);

    // Correct prediction, direction mispredict, target mispredict with backpressure.
    step(1, 1, 32'h100, 1, 32'h140, 1, 32'h140, 1, 0);
    idle(1);
    chk("cnt_after_correct", {cnt_branch, cnt_mispred}, {4'd1, 4'd0});
    step(1, 1, 32'h200, 0, 32'h240, 1, 32'h240, 1, 0);
    chk("dir_redir_pc", redir_pc, 32'h204);
    idle(1);
    idle(1);
    step(1, 1, 32'h2800, 1, 32'h3000, 1, 32'h2000, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 32'h2900 + 32'(i*4), 1, 32'h500, 0, '0, 0, 0);
    chk("bp_redir_pc", redir_pc, 32'h3000);
    idle(1);
    chk("bp_idle_after", redir_valid, 0);
    chk("bp_cnt_branch", cnt_branch, 4'd3);
    step(1, 1, 32'hFFFF_FFFC, 0, 32'h80, 1, 32'h80, 1, 0);
    chk("wrap_redir_pc", redir_pc, 32'h0);
    idle(1);

    // Saturation and clear-over-increment.
    step(0, 0, '0, 0, '0, 0, '0, 1, 1);
    for (int i = 0; i < 17; i++) step(1, 1, 32'h1000 + 32'(i*4), 1, 32'h40, 1, 32'h40, 1, 0);
    chk("sat_cnt_branch", cnt_branch, 4'd15);
    step(1, 1, 32'h2000, 1, 32'h40, 1, 32'h40, 1, 1);
    chk("clr_wins", cnt_branch, 4'd0);

    for (int i = 0; i < 3000; i++) begin
      pc   = ($urandom % 16 == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      e    = 1'($urandom);
      addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom % 3 != 0) begin
        pt = e; ptgt = addr;
      end else begin
        pt = 1'($urandom); ptgt = ($urandom % 2 == 0) ? addr : {$urandom_range(0, 255), 2'b00};
      end
      step($urandom % 4 != 0, $urandom % 3 != 0, pc, e, addr, pt, ptgt,
           $urandom % 3 != 0, $urandom % 60 == 0);
    end
    idle(1); idle(1);

    // Asynchronous reset while a redirect is held.
    step(1, 1, 32'h400, 0, 32'h480, 1, 32'h480, 0, 0);
    idle(0);
    chk("pre_rst_redir_valid", redir_valid, 1);
    mon_en = 0;
    #2 rst = 1;
    #1;
    chk("async_redir_valid", redir_valid, 0);
    chk("async_flush", flush_fe, 0);
    chk("async_stall", ex_stall, 0);
    @(posedge clk); #1;
    idle(0);
    rst = 0; mon_en = 1;
    step(1, 1, 32'h600, 1, 32'h700, 1, 32'h700, 0, 0);
    idle(0);
    chk("post_rst_cnt", cnt_branch, 4'd1);
    idle(1); idle(1);

    chk("upd_q_drained", upd_q.size(), 0);
    chk("redir_q_drained", redir_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
